cnt_if_ctr: RTL and testbench

Parameterised synchronous up/down counter with parallel load and an all-ones terminal indicator. Sits behind the team's counter interface bundle (cnt_if signal set). Drives count and status back to the testbench or host logic. One clock domain, no internal handshakes.

---
 rtl/cnt_pkg.sv | 40 ++++
 rtl/cnt_wrap_det.sv | 45 ++++
 rtl/cnt_if_ctr.sv | 63 ++++++
 tb/tb_cnt_if_ctr.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// ============================================================================
//  Module   : cnt_pkg
//  Brief    : Shared types and helpers for the cnt_if counter block.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_pkg;

    localparam int CNT_WIDTH_DEFAULT = 4;

    // Operation chosen for the coming clock edge, in priority order
    // LOAD > UP/DN > HOLD.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_UP   = 2'd2,
        CNT_DN   = 2'd3
    } cnt_op_e;

    // Resolve the control inputs into a single operation. Load wins over
    // enable regardless of direction.
    function automatic cnt_op_e decode_op(input logic load_en,
                                          input logic en,
                                          input logic down);
        cnt_op_e op;
        if (load_en)
            op = CNT_LOAD;
        else if (en && !down)
            op = CNT_UP;
        else if (en && down)
            op = CNT_DN;
        else
            op = CNT_HOLD;
        return op;
    endfunction

endpackage : cnt_pkg

`default_nettype wire

// File: rtl/cnt_wrap_det.sv
// ============================================================================
//  Module   : cnt_wrap_det
//  Brief    : Registered wrap-around pulse detector. Flags the cycle after an
//             increment from all ones to zero (wrap_up) or a decrement from
//             zero to all ones (wrap_dn).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_wrap_det
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  cnt_op_e          op,
    output logic             wrap_up,
    output logic             wrap_dn
);

    // Pre-edge view of the counter: the wrap is decided from the value that is
    // about to be stepped, so the pulse lines up with the new count.
    logic at_max;
    logic at_zero;

    assign at_max  = &count;
    assign at_zero = (count == '0);

    // Pulses last exactly one cycle; load and hold always clear them, and the
    // two cannot coexist because op selects a single direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
        end else begin
            wrap_up <= (op == CNT_UP) && at_max;
            wrap_dn <= (op == CNT_DN) && at_zero;
        end
    end

endmodule : cnt_wrap_det

`default_nettype wire

// File: rtl/cnt_if_ctr.sv
// ============================================================================
//  Module   : cnt_if_ctr
//  Brief    : Parameterised up/down counter with parallel load, all-ones
//             rollover flag and registered wrap pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_if_ctr
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load,
    input  logic             down,
    output logic [WIDTH-1:0] count,
    output logic             rollover,
    output logic             wrap_up,
    output logic             wrap_dn
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    cnt_op_e op;

    assign op = decode_op(load_en, en, down);

    // Counter register: steps modulo 2^WIDTH via natural overflow of the
    // fixed-width add/subtract.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case (op)
                CNT_LOAD: count <= load;
                CNT_UP:   count <= count + C_ONE;
                CNT_DN:   count <= count - C_ONE;
                default:  count <= count;
            endcase
        end
    end

    // Terminal indicator is purely a function of the stored count.
    assign rollover = &count;

    cnt_wrap_det #(
        .WIDTH (WIDTH)
    ) u_wrap_det (
        .clk     (clk),
        .rst     (rst),
        .count   (count),
        .op      (op),
        .wrap_up (wrap_up),
        .wrap_dn (wrap_dn)
    );

endmodule : cnt_if_ctr

`default_nettype wire

// File: tb/tb_cnt_if_ctr.sv
// ============================================================================
//  Module   : tb_cnt_if_ctr
//  Brief    : Self-checking bench for cnt_if_ctr (WIDTH=4 and WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_if_ctr;

    logic       clk;
    logic       rst;

    // WIDTH=4 instance
    logic       en, load_en, down;
    logic [3:0] load;
    logic [3:0] count;
    logic       rollover, wrap_up, wrap_dn;

    // WIDTH=8 instance
    logic       en8, load_en8, down8;
    logic [7:0] load8;
    logic [7:0] count8;
    logic       rollover8, wrap_up8, wrap_dn8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (values as plain integers)
    int m_cnt, m_wu, m_wd;
    int m8_cnt, m8_wu, m8_wd;

    cnt_if_ctr #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .load_en(load_en), .load(load),
        .down(down), .count(count), .rollover(rollover),
        .wrap_up(wrap_up), .wrap_dn(wrap_dn)
    );

    cnt_if_ctr #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .load_en(load_en8), .load(load8),
        .down(down8), .count(count8), .rollover(rollover8),
        .wrap_up(wrap_up8), .wrap_dn(wrap_dn8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural next-state: modular arithmetic on integer values.
    task automatic model_next(input int modulus, input bit ld, input int ldv,
                              input bit e, input bit dn,
                              inout int c, output int wu, output int wd);
        wu = 0;
        wd = 0;
        if (ld) begin
            c = ldv;
        end else if (e && !dn) begin
            wu = (c == modulus - 1);
            c  = (c + 1) % modulus;
        end else if (e && dn) begin
            wd = (c == 0);
            c  = (c + modulus - 1) % modulus;
        end
    endtask

    // Apply current 4-bit inputs at the next edge, then sample 1 time unit later.
    task automatic step4();
        @(posedge clk);
        model_next(16, load_en, int'(load), en, down, m_cnt, m_wu, m_wd);
        #1;
    endtask

    task automatic step8();
        @(posedge clk);
        model_next(256, load_en8, int'(load8), en8, down8, m8_cnt, m8_wu, m8_wd);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 1'b1; load = 4'h9; en = 1'b1; down = 1'b0;
        load_en8 = 1'b0; load8 = 8'h00; en8 = 1'b0; down8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_cnt = 0; m_wu = 0; m_wd = 0;
        m8_cnt = 0; m8_wu = 0; m8_wd = 0;
        n_checks++;
        if (count !== 4'h0 || rollover !== 1'b0 || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%h roll=%b wu=%b wd=%b, required 0 0 0 0",
                     count, rollover, wrap_up, wrap_dn);
        end
        n_checks++;
        if (count8 !== 8'h00 || rollover8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state8: count=%h roll=%b, required 00 0", count8, rollover8);
        end
        #3;
        rst = 1'b0; load_en = 1'b0; en = 1'b0;
    endtask

    task automatic test_load_priority();
        load_en = 1'b1; load = 4'h1; down = 1'b1; en = 1'b1;
        step4();
        n_checks++;
        if (count !== 4'h1) begin
            n_fail++;
            $display("FAIL load_pri_en1: count=%h, required 1", count);
        end
        load = 4'hC; en = 1'b0;
        step4();
        n_checks++;
        if (count !== 4'hC || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
            n_fail++;
            $display("FAIL load_pri_en0: count=%h wu=%b wd=%b, required c 0 0",
                     count, wrap_up, wrap_dn);
        end
        // Loading the boundary values never produces a pulse.
        load = 4'hF; en = 1'b1; down = 1'b0;
        step4();
        load = 4'h0;
        step4();
        n_checks++;
        if (count !== 4'h0 || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
            n_fail++;
            $display("FAIL load_no_wrap: count=%h wu=%b wd=%b, required 0 0 0",
                     count, wrap_up, wrap_dn);
        end
        load_en = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_seq [4] = '{4'h0, 4'hF, 4'hE, 4'hD};
        load_en = 1'b1; load = 4'h1; en = 1'b0;
        step4();
        load_en = 1'b0; en = 1'b1; down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step4();
            n_checks++;
            if (count !== exp_seq[i] || count !== 4'(m_cnt) ||
                rollover !== (exp_seq[i] == 4'hF) ||
                wrap_dn !== (i == 1) || wrap_up !== 1'b0) begin
                n_fail++;
                $display("FAIL down_wrap[%0d]: count=%h roll=%b wu=%b wd=%b, required %h %b 0 %b",
                         i, count, rollover, wrap_up, wrap_dn, exp_seq[i],
                         exp_seq[i] == 4'hF, i == 1);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_seq [3] = '{4'hF, 4'h0, 4'h1};
        load_en = 1'b1; load = 4'hE;
        step4();
        load_en = 1'b0; en = 1'b1; down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step4();
            n_checks++;
            if (count !== exp_seq[i] || rollover !== (i == 0) ||
                wrap_up !== (i == 1) || wrap_dn !== 1'b0) begin
                n_fail++;
                $display("FAIL up_wrap[%0d]: count=%h roll=%b wu=%b wd=%b, required %h %b %b 0",
                         i, count, rollover, wrap_up, wrap_dn, exp_seq[i], i == 0, i == 1);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_hold();
        load_en = 1'b1; load = 4'h7;
        step4();
        load_en = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            down = ~down;
            step4();
            n_checks++;
            if (count !== 4'h7 || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: count=%h wu=%b wd=%b, required 7 0 0",
                         i, count, wrap_up, wrap_dn);
            end
        end
    endtask

    task automatic test_async_reset();
        load_en = 1'b1; load = 4'h5;
        step4();
        load_en = 1'b1; load = 4'hA; en = 1'b1;   // pending load, discarded by reset
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 4'h0 || rollover !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: count=%h roll=%b, required 0 0", count, rollover);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (count !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_discards_load: count=%h, required 0", count);
        end
        #2;
        rst = 1'b0; load_en = 1'b0; en = 1'b0;
        m_cnt = 0; m_wu = 0; m_wd = 0;
        m8_cnt = 0; m8_wu = 0; m8_wd = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            load_en = ($urandom_range(0, 7) == 0);
            load    = 4'($urandom_range(0, 15));
            en      = ($urandom_range(0, 3) != 0);
            down    = 1'($urandom_range(0, 1));
            step4();
            n_checks++;
            if (count !== 4'(m_cnt) || rollover !== (m_cnt == 15) ||
                wrap_up !== 1'(m_wu) || wrap_dn !== 1'(m_wd) ||
                (wrap_up && wrap_dn)) begin
                n_fail++;
                $display("FAIL random[%0d]: count=%h roll=%b wu=%b wd=%b, required %h %b %0d %0d",
                         i, count, rollover, wrap_up, wrap_dn, 4'(m_cnt), m_cnt == 15, m_wu, m_wd);
            end
        end
        load_en = 1'b0; en = 1'b0;
    endtask

    task automatic test_width8();
        load_en8 = 1'b1; load8 = 8'hFF;
        step8();
        n_checks++;
        if (count8 !== 8'hFF || rollover8 !== 1'b1 || wrap_up8 !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_load_ff: count=%h roll=%b wu=%b, required ff 1 0",
                     count8, rollover8, wrap_up8);
        end
        load_en8 = 1'b0; en8 = 1'b1; down8 = 1'b0;
        step8();
        n_checks++;
        if (count8 !== 8'h00 || rollover8 !== 1'b0 || wrap_up8 !== 1'b1 || wrap_dn8 !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_wrap_up: count=%h roll=%b wu=%b wd=%b, required 00 0 1 0",
                     count8, rollover8, wrap_up8, wrap_dn8);
        end
        for (int i = 0; i < 150; i++) begin
            load_en8 = ($urandom_range(0, 15) == 0);
            load8    = ($urandom_range(0, 1) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
            en8      = ($urandom_range(0, 3) != 0);
            down8    = 1'($urandom_range(0, 1));
            step8();
            n_checks++;
            if (count8 !== 8'(m8_cnt) || rollover8 !== (m8_cnt == 255) ||
                wrap_up8 !== 1'(m8_wu) || wrap_dn8 !== 1'(m8_wd)) begin
                n_fail++;
                $display("FAIL w8_random[%0d]: count=%h roll=%b wu=%b wd=%b, required %h %b %0d %0d",
                         i, count8, rollover8, wrap_up8, wrap_dn8, 8'(m8_cnt),
                         m8_cnt == 255, m8_wu, m8_wd);
            end
        end
        load_en8 = 1'b0; en8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_priority();
        test_down_wrap();
        test_up_wrap();
        test_hold();
        test_async_reset();
        test_random();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cnt_if_ctr

`default_nettype wire
